// File: rtl/axi_pcie_v1_06_a_axi_enhanced_tx_fc_gate.sv
// Transmit flow-control credit gate: shadows the block's available TX credits and
// qualifies RR/RW/CC TLP starts so the arbiter never overcommits during report latency.
module axi_pcie_v1_06_a_axi_enhanced_tx_fc_gate #(
    parameter int unsigned C_FC_LAT       = 4,
    parameter string       C_CPL_INFINITE = "FALSE",
    parameter int unsigned TCQ            = 1
) (
    input  logic        com_iclk,
    input  logic        com_sysrst,
    input  logic        trn_lnk_up,
    output logic [2:0]  trn_fc_sel,
    input  logic [7:0]  trn_fc_ph,
    input  logic [11:0] trn_fc_pd,
    input  logic [7:0]  trn_fc_nph,
    input  logic [7:0]  trn_fc_cplh,
    input  logic [11:0] trn_fc_cpld,
    input  logic [9:0]  rw_len,
    input  logic [9:0]  cc_len,
    input  logic        cc_has_data,
    input  logic        rr_start,
    input  logic        rw_start,
    input  logic        cc_start,
    output logic        rr_credit_ok,
    output logic        rw_credit_ok,
    output logic        cc_credit_ok,
    output logic        fc_err
);

    localparam int unsigned HDR_W  = 8;
    localparam int unsigned DAT_W  = 12;
    localparam int unsigned HOLD_W = (C_FC_LAT < 1) ? 1 : $clog2(C_FC_LAT + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(C_FC_LAT);
    localparam bit CPL_INF = (C_CPL_INFINITE == "TRUE");

    typedef enum logic [1:0] {
        LINK_DOWN = 2'd0,
        WARMUP    = 2'd1,
        RUN       = 2'd2
    } state_t;

    // Data credits for a DW length: ceil(len/4), with len 0 meaning 1024 DW.
    function automatic logic [8:0] dc_need(input logic [9:0] len);
        logic [10:0] sum;
        sum = {1'b0, len} + 11'd3;
        dc_need = (len == 10'd0) ? 9'd256 : sum[10:2];
    endfunction

    state_t            state_q, state_nxt;
    logic [HOLD_W-1:0] hold_q, hold_nxt;
    logic [HDR_W-1:0]  nph_sh, ph_sh, cplh_sh;
    logic [HDR_W-1:0]  nph_nxt, ph_nxt, cplh_nxt;
    logic [DAT_W-1:0]  pd_sh, cpld_sh;
    logic [DAT_W-1:0]  pd_nxt, cpld_nxt;
    logic              rr_ok_nxt, rw_ok_nxt, cc_ok_nxt, err_nxt;
    logic [DAT_W-1:0]  rw_need, cc_need;
    logic              any_start, run_c;
    logic              unused_tcq;

    assign trn_fc_sel = 3'b100;
    assign unused_tcq = TCQ[0];

    assign rw_need   = DAT_W'(dc_need(rw_len));
    assign cc_need   = DAT_W'(dc_need(cc_len));
    assign any_start = rr_start | rw_start | cc_start;
    assign run_c     = (state_q == RUN) && trn_lnk_up;

    // State register
    always_ff @(posedge com_iclk) begin
        if (com_sysrst) begin
            state_q <= LINK_DOWN;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Shadow counters, holdoff and registered outputs
    always_ff @(posedge com_iclk) begin
        if (com_sysrst) begin
            hold_q       <= '0;
            nph_sh       <= '0;
            ph_sh        <= '0;
            cplh_sh      <= '0;
            pd_sh        <= '0;
            cpld_sh      <= '0;
            rr_credit_ok <= 1'b0;
            rw_credit_ok <= 1'b0;
            cc_credit_ok <= 1'b0;
            fc_err       <= 1'b0;
        end else begin
            hold_q       <= hold_nxt;
            nph_sh       <= nph_nxt;
            ph_sh        <= ph_nxt;
            cplh_sh      <= cplh_nxt;
            pd_sh        <= pd_nxt;
            cpld_sh      <= cpld_nxt;
            rr_credit_ok <= rr_ok_nxt;
            rw_credit_ok <= rw_ok_nxt;
            cc_credit_ok <= cc_ok_nxt;
            fc_err       <= err_nxt;
        end
    end

    // Next-state, shadow update and credit qualification
    always_comb begin
        state_nxt = state_q;
        hold_nxt  = hold_q;
        nph_nxt   = nph_sh;
        ph_nxt    = ph_sh;
        cplh_nxt  = cplh_sh;
        pd_nxt    = pd_sh;
        cpld_nxt  = cpld_sh;
        err_nxt   = fc_err;

        if ((rr_start && !rr_credit_ok) || (rw_start && !rw_credit_ok) ||
            (cc_start && !cc_credit_ok)) begin
            err_nxt = 1'b1;
        end

        unique case (state_q)
            LINK_DOWN: begin
                nph_nxt  = '0;
                ph_nxt   = '0;
                cplh_nxt = '0;
                pd_nxt   = '0;
                cpld_nxt = '0;
                hold_nxt = '0;
                if (trn_lnk_up) begin
                    hold_nxt  = HOLD_LOAD;
                    state_nxt = WARMUP;
                end
            end
            WARMUP: begin
                if (hold_q != '0) begin
                    hold_nxt = hold_q - HOLD_W'(1);
                end else begin
                    nph_nxt   = trn_fc_nph;
                    ph_nxt    = trn_fc_ph;
                    cplh_nxt  = trn_fc_cplh;
                    pd_nxt    = trn_fc_pd;
                    cpld_nxt  = trn_fc_cpld;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (any_start) begin
                    hold_nxt = HOLD_LOAD;
                    if (rr_start) begin
                        if (nph_sh == '0) err_nxt = 1'b1;
                        else              nph_nxt = nph_sh - HDR_W'(1);
                    end
                    if (rw_start) begin
                        if (ph_sh == '0) err_nxt = 1'b1;
                        else             ph_nxt  = ph_sh - HDR_W'(1);
                        if (pd_sh < rw_need) begin
                            pd_nxt  = '0;
                            err_nxt = 1'b1;
                        end else begin
                            pd_nxt = pd_sh - rw_need;
                        end
                    end
                    // Completion pools still track usage when infinite, but never flag
                    if (cc_start) begin
                        if (cplh_sh == '0) begin
                            if (!CPL_INF) err_nxt = 1'b1;
                        end else begin
                            cplh_nxt = cplh_sh - HDR_W'(1);
                        end
                        if (cc_has_data) begin
                            if (cpld_sh < cc_need) begin
                                cpld_nxt = '0;
                                if (!CPL_INF) err_nxt = 1'b1;
                            end else begin
                                cpld_nxt = cpld_sh - cc_need;
                            end
                        end
                    end
                end else if (hold_q != '0) begin
                    hold_nxt = hold_q - HOLD_W'(1);
                end else begin
                    nph_nxt  = trn_fc_nph;
                    ph_nxt   = trn_fc_ph;
                    cplh_nxt = trn_fc_cplh;
                    pd_nxt   = trn_fc_pd;
                    cpld_nxt = trn_fc_cpld;
                end
            end
            default: begin
                state_nxt = LINK_DOWN;
            end
        endcase

        // Link loss overrides everything, including mid-packet
        if (!trn_lnk_up) begin
            state_nxt = LINK_DOWN;
            hold_nxt  = '0;
            nph_nxt   = '0;
            ph_nxt    = '0;
            cplh_nxt  = '0;
            pd_nxt    = '0;
            cpld_nxt  = '0;
        end

        rr_ok_nxt = run_c && (nph_sh != '0) && !rr_start;
        rw_ok_nxt = run_c && (ph_sh != '0) && (pd_sh >= rw_need) && !rw_start;
        cc_ok_nxt = run_c && !cc_start &&
                    (CPL_INF || ((cplh_sh != '0) && (!cc_has_data || (cpld_sh >= cc_need))));
    end

endmodule

// File: tb/tb_axi_pcie_v1_06_a_axi_enhanced_tx_fc_gate.sv
// Bench for the TX flow-control credit gate: cycle-by-cycle vector table plus
// hand-written sequences for completion-infinite mode, sticky error and reset.
module tb_axi_pcie_v1_06_a_axi_enhanced_tx_fc_gate;

    logic        clk = 1'b0;
    logic        rst;
    logic        up;
    logic [7:0]  fc_ph, fc_nph, fc_cplh;
    logic [11:0] fc_pd, fc_cpld;
    logic [9:0]  rw_len, cc_len;
    logic        cc_hd, rr_s, rw_s, cc_s;
    logic [2:0]  sel, sel_inf;
    logic        rr_ok, rw_ok, cc_ok, err;
    logic        rr_ok_i, rw_ok_i, cc_ok_i, err_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_pcie_v1_06_a_axi_enhanced_tx_fc_gate #(
        .C_FC_LAT(4), .C_CPL_INFINITE("FALSE"), .TCQ(1)
    ) dut (
        .com_iclk(clk), .com_sysrst(rst), .trn_lnk_up(up), .trn_fc_sel(sel),
        .trn_fc_ph(fc_ph), .trn_fc_pd(fc_pd), .trn_fc_nph(fc_nph),
        .trn_fc_cplh(fc_cplh), .trn_fc_cpld(fc_cpld),
        .rw_len(rw_len), .cc_len(cc_len), .cc_has_data(cc_hd),
        .rr_start(rr_s), .rw_start(rw_s), .cc_start(cc_s),
        .rr_credit_ok(rr_ok), .rw_credit_ok(rw_ok), .cc_credit_ok(cc_ok), .fc_err(err)
    );

    axi_pcie_v1_06_a_axi_enhanced_tx_fc_gate #(
        .C_FC_LAT(4), .C_CPL_INFINITE("TRUE"), .TCQ(1)
    ) dut_inf (
        .com_iclk(clk), .com_sysrst(rst), .trn_lnk_up(up), .trn_fc_sel(sel_inf),
        .trn_fc_ph(fc_ph), .trn_fc_pd(fc_pd), .trn_fc_nph(fc_nph),
        .trn_fc_cplh(fc_cplh), .trn_fc_cpld(fc_cpld),
        .rw_len(rw_len), .cc_len(cc_len), .cc_has_data(cc_hd),
        .rr_start(rr_s), .rw_start(rw_s), .cc_start(cc_s),
        .rr_credit_ok(rr_ok_i), .rw_credit_ok(rw_ok_i), .cc_credit_ok(cc_ok_i), .fc_err(err_i)
    );

    typedef struct {
        logic        up;
        logic [7:0]  ph, nph, cplh;
        logic [11:0] pd, cpld;
        logic [9:0]  rw_len, cc_len;
        logic        hd;
        logic [2:0]  st;     // {rr, rw, cc} start pulses
        logic [5:0]  ex;     // {rr_ok, rw_ok, cc_ok, err, inf cc_ok, inf err}
        logic        chk;
        logic [7:0]  e_nph, e_ph, e_cplh;
        logic [11:0] e_pd, e_cpld;
    } vec_t;

    vec_t vq[$];

    logic [7:0]  c_ph, c_nph, c_cplh;
    logic [11:0] c_pd, c_cpld;
    logic [9:0]  c_rwl, c_ccl;
    logic        c_hd;

    task automatic set_in(input logic [7:0] ph, input logic [11:0] pd, input logic [7:0] nph,
                          input logic [7:0] cplh, input logic [11:0] cpld,
                          input logic [9:0] rwl, input logic [9:0] ccl, input logic hd);
        c_ph = ph; c_pd = pd; c_nph = nph; c_cplh = cplh; c_cpld = cpld;
        c_rwl = rwl; c_ccl = ccl; c_hd = hd;
    endtask

    task automatic add_sh(input logic u, input logic [2:0] st, input logic [5:0] ex,
                          input logic chk, input logic [7:0] e_nph, input logic [7:0] e_ph,
                          input logic [11:0] e_pd, input logic [7:0] e_cplh,
                          input logic [11:0] e_cpld);
        vec_t v;
        v.up = u; v.ph = c_ph; v.pd = c_pd; v.nph = c_nph; v.cplh = c_cplh; v.cpld = c_cpld;
        v.rw_len = c_rwl; v.cc_len = c_ccl; v.hd = c_hd; v.st = st; v.ex = ex;
        v.chk = chk; v.e_nph = e_nph; v.e_ph = e_ph; v.e_pd = e_pd;
        v.e_cplh = e_cplh; v.e_cpld = e_cpld;
        vq.push_back(v);
    endtask

    task automatic add(input logic u, input logic [2:0] st, input logic [5:0] ex);
        add_sh(u, st, ex, 1'b0, 8'd0, 8'd0, 12'd0, 8'd0, 12'd0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply(input vec_t v);
        up = v.up; fc_ph = v.ph; fc_pd = v.pd; fc_nph = v.nph; fc_cplh = v.cplh;
        fc_cpld = v.cpld; rw_len = v.rw_len; cc_len = v.cc_len; cc_hd = v.hd;
        {rr_s, rw_s, cc_s} = v.st;
    endtask

    initial begin
        rst = 1'b1; up = 1'b0;
        fc_ph = '0; fc_pd = '0; fc_nph = '0; fc_cplh = '0; fc_cpld = '0;
        rw_len = '0; cc_len = '0; cc_hd = 1'b0; rr_s = 1'b0; rw_s = 1'b0; cc_s = 1'b0;

        // Vector table, one entry per clock.
        // Set A: ph2 pd16 nph3 cplh2 cpld8, rw_len 64 (16 data), cc_len 8 (2 data)
        set_in(8'd2, 12'd16, 8'd3, 8'd2, 12'd8, 10'd64, 10'd8, 1'b1);
        for (int i = 0; i < 6; i++) add(1'b1, 3'b000, 6'b000000);
        add(1'b1, 3'b000, 6'b111010);
        add_sh(1'b1, 3'b010, 6'b101010, 1'b1, 8'd3, 8'd1, 12'd0, 8'd2, 12'd8);
        for (int i = 0; i < 5; i++) add(1'b1, 3'b000, 6'b101010);
        add(1'b1, 3'b000, 6'b111010);
        // rw_len 0 needs 256 data credits
        set_in(8'd2, 12'd255, 8'd3, 8'd2, 12'd8, 10'd0, 10'd8, 1'b1);
        add(1'b1, 3'b000, 6'b101010);
        add(1'b1, 3'b000, 6'b101010);
        set_in(8'd2, 12'd256, 8'd3, 8'd2, 12'd8, 10'd0, 10'd8, 1'b1);
        add(1'b1, 3'b000, 6'b101010);
        add(1'b1, 3'b000, 6'b111010);
        // Set D: single header credits, rw_len 4, cc_len 5 (2 data)
        set_in(8'd1, 12'd16, 8'd1, 8'd1, 12'd8, 10'd4, 10'd5, 1'b1);
        add(1'b1, 3'b000, 6'b111010);
        add(1'b1, 3'b000, 6'b111010);
        add_sh(1'b1, 3'b111, 6'b000000, 1'b1, 8'd0, 8'd0, 12'd15, 8'd0, 12'd6);
        add(1'b1, 3'b000, 6'b000010);
        // cc_start without credit: error, header saturates
        add_sh(1'b1, 3'b001, 6'b000100, 1'b1, 8'd0, 8'd0, 12'd15, 8'd0, 12'd4);
        for (int i = 0; i < 5; i++) add(1'b1, 3'b000, 6'b000110);
        add(1'b1, 3'b000, 6'b111110);
        add(1'b1, 3'b010, 6'b101110);
        // Link drop during holdoff, then relink
        add_sh(1'b0, 3'b000, 6'b000100, 1'b1, 8'd0, 8'd0, 12'd0, 8'd0, 12'd0);
        for (int i = 0; i < 6; i++) add(1'b1, 3'b000, 6'b000100);
        add(1'b1, 3'b000, 6'b111110);

        // Reset state
        @(negedge clk);
        step(); step();
        check("reset fc_sel", 32'(sel), 32'd4);
        check("reset oks", 32'({rr_ok, rw_ok, cc_ok, cc_ok_i}), 32'd0);
        check("reset fc_err", 32'({err, err_i}), 32'd0);
        check("reset pd_sh", 32'(dut.pd_sh), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i]);
            step();
            check($sformatf("v%0d rr_ok", i), 32'(rr_ok), 32'(vq[i].ex[5]));
            check($sformatf("v%0d rw_ok", i), 32'(rw_ok), 32'(vq[i].ex[4]));
            check($sformatf("v%0d cc_ok", i), 32'(cc_ok), 32'(vq[i].ex[3]));
            check($sformatf("v%0d fc_err", i), 32'(err), 32'(vq[i].ex[2]));
            check($sformatf("v%0d inf cc_ok", i), 32'(cc_ok_i), 32'(vq[i].ex[1]));
            check($sformatf("v%0d inf fc_err", i), 32'(err_i), 32'(vq[i].ex[0]));
            if (vq[i].chk) begin
                check($sformatf("v%0d nph_sh", i), 32'(dut.nph_sh), 32'(vq[i].e_nph));
                check($sformatf("v%0d ph_sh", i), 32'(dut.ph_sh), 32'(vq[i].e_ph));
                check($sformatf("v%0d pd_sh", i), 32'(dut.pd_sh), 32'(vq[i].e_pd));
                check($sformatf("v%0d cplh_sh", i), 32'(dut.cplh_sh), 32'(vq[i].e_cplh));
                check($sformatf("v%0d cpld_sh", i), 32'(dut.cpld_sh), 32'(vq[i].e_cpld));
            end
        end

        // Infinite completion credits: cc_ok ignores cplh=0 except after a start
        fc_cplh = 8'd0; cc_hd = 1'b1;
        step(); step();
        check("inf cplh0 main cc_ok", 32'(cc_ok), 32'd0);
        check("inf cplh0 inf cc_ok", 32'(cc_ok_i), 32'd1);
        cc_s = 1'b1;
        step();
        cc_s = 1'b0;
        check("inf guard cc_ok", 32'(cc_ok_i), 32'd0);
        step();
        check("inf after guard cc_ok", 32'(cc_ok_i), 32'd1);
        check("inf no err", 32'(err_i), 32'd0);

        // fc_err is sticky until reset
        for (int i = 0; i < 3; i++) step();
        check("err sticky", 32'(err), 32'd1);
        rst = 1'b1;
        step();
        check("err cleared by reset", 32'(err), 32'd0);
        check("oks cleared by reset", 32'({rr_ok, rw_ok, cc_ok}), 32'd0);
        check("fc_sel in reset", 32'(sel), 32'd4);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("relink warmup %0d rr_ok", i), 32'({rr_ok, rw_ok}), 32'd0);
        end
        step();
        check("relink run rr/rw ok", 32'({rr_ok, rw_ok}), 32'd3);
        check("relink run cc_ok main/inf", 32'({cc_ok, cc_ok_i}), 32'd1);
        check("relink fc_err", 32'(err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
